// File: rtl/event_fifo.sv
// event_fifo: circular-buffer FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags, selectable registered or
// first-word-fall-through read, and optional drop-oldest on write-to-full.
module event_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 7,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0,
    parameter int DROP_OLDEST   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    input  logic                  clear_flags,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Thresholds sized to the count so every compare is width-matched.
    localparam logic [ADDR_WIDTH:0] FULL_LVL   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic rd_accept;
    logic wr_accept;
    logic wr_blocked;
    logic overwrite;
    logic mem_we;
    logic rd_adv;
    logic drop_mode;

    // Status is a pure function of the registered count, so it tracks count
    // with no added latency.
    assign fifo_full    = (count == FULL_LVL);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= AFULL_LVL);
    assign almost_empty = (count <= AEMPTY_LVL);

    assign drop_mode  = (DROP_OLDEST != 0);

    // A pop frees a slot in the same cycle, so a write to a full FIFO is
    // still accepted when it is paired with an accepted read.
    assign rd_accept  = rd & ~fifo_empty;
    assign wr_accept  = wr & (~fifo_full | rd_accept);
    assign wr_blocked = wr & fifo_full & ~rd_accept;

    // Drop-oldest: the blocked write replaces the head; both pointers move
    // together so occupancy stays at DEPTH.
    assign overwrite  = wr_blocked & drop_mode;
    assign mem_we     = wr_accept | overwrite;
    assign rd_adv     = rd_accept | overwrite;

    // Storage array; contents are never reset, pointers/count guard validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Read/write pointers wrap naturally at DEPTH through their bit width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: only a lone accepted write or a lone accepted read changes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_blocked) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end

            if (rd & fifo_empty) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is always visible; forced to zero while empty so the
            // output is defined out of reset.
            assign data_out = fifo_empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            // Registered read: capture the head on the edge that pops it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_out <= '0;
                end else if (rd_accept) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_event_fifo.sv
// tb_event_fifo: three event_fifo instances (registered/keep-oldest,
// registered/drop-oldest, FWFT/keep-oldest) driven by one shared stimulus
// stream, with per-instance scoreboard queues for read data.
module tb_event_fifo;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NDUT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clear_flags = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout   [NDUT];
    logic          full   [NDUT];
    logic          empty  [NDUT];
    logic          afull  [NDUT];
    logic          aempty [NDUT];
    logic          ovf    [NDUT];
    logic          udf    [NDUT];
    logic [AW:0]   cnt    [NDUT];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];

    logic rdchk = 1'b0;
    logic vld_reg = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        event_fifo #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .AFULL_THRESH (6),
            .AEMPTY_THRESH(1),
            .FWFT         ((g == 2) ? 1 : 0),
            .DROP_OLDEST  ((g == 1) ? 1 : 0)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .wr          (wr),
            .data_in     (data_in),
            .rd          (rd),
            .clear_flags (clear_flags),
            .data_out    (dout[g]),
            .fifo_full   (full[g]),
            .fifo_empty  (empty[g]),
            .almost_full (afull[g]),
            .almost_empty(aempty[g]),
            .count       (cnt[g]),
            .overflow    (ovf[g]),
            .underflow   (udf[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        q0.push_back(a);
        q1.push_back(b);
        q2.push_back(c);
    endtask

    task automatic pop_cmp(input int i);
        logic [DW-1:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL rdata%0d: got %0h with no expected entry queued", i, dout[i]);
        end else begin
            check($sformatf("rdata%0d", i), 32'(dout[i]), 32'(e));
        end
    endtask

    // Registered-read instances present data one cycle after the accepting edge.
    always @(posedge clk) vld_reg <= rdchk;

    // Monitor: compare read data away from the active edge.
    always @(negedge clk) begin
        if (vld_reg) begin
            pop_cmp(0);
            pop_cmp(1);
        end
        if (rdchk) begin
            pop_cmp(2);
        end
    end

    // One clock of stimulus; chk marks a read expected to return data.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic chk);
        wr = w;
        data_in = d;
        rd = r;
        clear_flags = c;
        rdchk = chk;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        clear_flags = 1'b0;
        rdchk = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_count%0d", i), 32'(cnt[i]), 32'd0);
            check($sformatf("rst_empty%0d", i), 32'(empty[i]), 32'd1);
            check($sformatf("rst_dout%0d", i), 32'(dout[i]), 32'd0);
        end
        check("rst_full", 32'(full[0]), 32'd0);
        check("rst_aempty", 32'(aempty[0]), 32'd1);
        check("rst_afull", 32'(afull[0]), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);
        check("rst_udf", 32'(udf[0]), 32'd0);
        reset = 1'b1;

        // Fill with 0xAA..0xB1
        for (int i = 0; i < 8; i++) begin
            v = 8'hAA + 8'(i);
            cyc(1'b1, v, 1'b0, 1'b0, 1'b0);
            check($sformatf("fill_count_%0d", i), 32'(cnt[0]), 32'(i + 1));
            check($sformatf("fill_afull_%0d", i), 32'(afull[0]), 32'(i >= 5));
            check($sformatf("fill_full_%0d", i), 32'(full[0]), 32'(i == 7));
            check($sformatf("fill_aempty_%0d", i), 32'(aempty[0]), 32'(i == 0));
        end

        // Write to full
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("ovf_set%0d", i), 32'(ovf[i]), 32'd1);
            check($sformatf("ovf_count%0d", i), 32'(cnt[i]), 32'd8);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_clr0", 32'(ovf[0]), 32'd0);
        check("ovf_clr1", 32'(ovf[1]), 32'd0);

        // Full with simultaneous write and read
        push3(8'hAA, 8'hAB, 8'hAA);
        cyc(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1);
        check("simul_count0", 32'(cnt[0]), 32'd8);
        check("simul_count1", 32'(cnt[1]), 32'd8);
        check("simul_ovf0", 32'(ovf[0]), 32'd0);
        check("simul_ovf1", 32'(ovf[1]), 32'd0);
        check("simul_full2", 32'(full[2]), 32'd1);

        // Drain
        for (int i = 0; i < 7; i++) begin
            push3(8'hAB + 8'(i), 8'hAC + 8'(i), 8'hAB + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        push3(8'hC0, 8'hC0, 8'hC0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("drain_empty%0d", i), 32'(empty[i]), 32'd1);
            check($sformatf("drain_count%0d", i), 32'(cnt[i]), 32'd0);
        end

        // Underflow and sticky clear
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("udf_set0", 32'(udf[0]), 32'd1);
        check("udf_set2", 32'(udf[2]), 32'd1);
        check("udf_dout0", 32'(dout[0]), 32'hC0);
        check("udf_dout1", 32'(dout[1]), 32'hC0);
        check("udf_count0", 32'(cnt[0]), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("udf_clr0", 32'(udf[0]), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("udf_setwins0", 32'(udf[0]), 32'd1);
        check("udf_setwins1", 32'(udf[1]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("udf_clr_again", 32'(udf[0]), 32'd0);

        // Write and read together while empty
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("wre_count0", 32'(cnt[0]), 32'd1);
        check("wre_udf0", 32'(udf[0]), 32'd1);
        check("wre_dout0", 32'(dout[0]), 32'hC0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        push3(8'h55, 8'h55, 8'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("wre_drain", 32'(cnt[0]), 32'd0);

        // Wrap: 300 write/read pairs
        for (int k = 0; k < 300; k++) begin
            v = 8'hAA + 8'(k);
            cyc(1'b1, v, 1'b0, 1'b0, 1'b0);
            push3(v, v, v);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("wrap_count%0d", i), 32'(cnt[i]), 32'd0);
            check($sformatf("wrap_ovf%0d", i), 32'(ovf[i]), 32'd0);
            check($sformatf("wrap_udf%0d", i), 32'(udf[i]), 32'd0);
        end

        // Asynchronous reset mid-clock with live contents
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        push3(8'h11, 8'h11, 8'h11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        #6;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("arst_count%0d", i), 32'(cnt[i]), 32'd0);
            check($sformatf("arst_empty%0d", i), 32'(empty[i]), 32'd1);
            check($sformatf("arst_dout%0d", i), 32'(dout[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("post_rst_udf0", 32'(udf[0]), 32'd1);
        check("post_rst_empty0", 32'(empty[0]), 32'd1);
        check("post_rst_dout0", 32'(dout[0]), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_left0", 32'(q0.size()), 32'd0);
        check("sb_left1", 32'(q1.size()), 32'd0);
        check("sb_left2", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/event_fifo.md
EVENT_FIFO -- requirements
Module: event_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of each stored entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, the almost-full level (count >= AFULL_THRESH).
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, the almost-empty level (count <= AEMPTY_THRESH).
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have parameter DROP_OLDEST, default 0: 0 = write to full is discarded, 1 = write to full overwrites the oldest entry.
REQ-007 SHALL have ports: clk  input  1  rising-edge clock.
REQ-008 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: wr  input  1  write request; data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports: rd  input  1  read/pop request; clear_flags  input  1  clears the sticky flags.
REQ-011 SHALL have ports: data_out  output  DATA_WIDTH  read data.
REQ-012 SHALL have ports: fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  status.
REQ-013 SHALL have ports: count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage SHALL be DEPTH x DATA_WIDTH; the write and read pointers SHALL wrap modulo DEPTH.
REQ-016 fifo_full SHALL equal (count == DEPTH); fifo_empty SHALL equal (count == 0); both derive from the registered count with no extra cycle of delay.
REQ-017 almost_full and almost_empty SHALL be combinational compares on the registered count.
REQ-018 A read SHALL be accepted when rd=1 and fifo_empty=0; it advances the read pointer.
REQ-019 A read with rd=1 and fifo_empty=1 SHALL not move any pointer, SHALL leave data_out unchanged, and SHALL set underflow at the next edge.
REQ-020 A write SHALL be accepted when wr=1 and either fifo_full=0 or a read is accepted in the same cycle.
REQ-021 Simultaneous accepted write and read SHALL leave count unchanged; with fifo_empty=1, the write is accepted and the read counts as an underflow.
REQ-022 With DROP_OLDEST=0, wr=1 with fifo_full=1 and no accepted read SHALL discard data_in, leave the contents unchanged, and set overflow.
REQ-023 With DROP_OLDEST=1, the same condition SHALL store data_in, advance both pointers, keep count=DEPTH, and set overflow.
REQ-024 With FWFT=0, data_out SHALL register the head entry at the edge that accepts a read, so it is valid one cycle after rd; otherwise it holds its value.
REQ-025 With FWFT=1, data_out SHALL present the head entry whenever fifo_empty=0, and SHALL show the first written word the cycle after the write into an empty FIFO.
REQ-026 With FWFT=1, rd SHALL pop the entry shown; data_out is don't-care while empty.
REQ-027 count SHALL be +1 per cycle on an accepted write alone, -1 on an accepted read alone, and unchanged otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-028 overflow and underflow SHALL stay set until clear_flags=1; if a clear and a new error event occur in the same cycle, the set SHALL win.

Reset
REQ-029 reset=0 SHALL asynchronously force: pointers=0, count=0, data_out=0, overflow=0, underflow=0, hence fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
REQ-030 Memory contents SHALL NOT need a reset; no entry written before reset SHALL be readable after it.
REQ-031 Reset deassertion SHALL be synchronised to clk externally; the block SHALL accept wr/rd on the first rising edge after deassertion.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=1 unless stated)
REQ-032 Reset: assert reset=0 mid-clock -> count=0, fifo_empty=1, data_out=0x00 immediately, without waiting for an edge.
REQ-033 Fill, DROP_OLDEST=0: write 0xAA..0xB1 -> almost_full after 6th write, fifo_full after 8th; write 0xB2 -> overflow=1, count=8; 8 reads return 0xAA..0xB1, then fifo_empty=1.
REQ-034 Fill, DROP_OLDEST=1: same stimulus -> overflow=1, count=8; reads return 0xAB..0xB2.
REQ-035 Full with simultaneous wr 0xC0 and rd -> count stays 8, overflow stays 0, 0xC0 read last.
REQ-036 Empty rd -> underflow=1, data_out unchanged; clear_flags=1 -> underflow=0; clear_flags together with a new empty rd -> underflow stays 1.
REQ-037 Wrap, both FWFT values: 300 single-entry write/read pairs starting at 0xAA, incrementing mod 256 -> every read matches its write (FWFT=0 one cycle after rd, FWFT=1 one cycle after wr); count returns to 0; no flags set.
